// File: rtl/mult_pkg.sv
// Shared types and sizing for the 16x16 shift-add multiplier control slice.
package mult_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned CW    = 5;
  localparam int unsigned ACC_W = 2 * N + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADDSH = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mult_ctrl_if.sv
// Handshake and accumulator-strobe bundle between the multiplier controller and its datapath.
interface mult_ctrl_if;
  import mult_pkg::*;

  logic          St;
  logic          M;
  logic          Load;
  logic          Ad;
  logic          Sh;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] Count;

  // master: issuing datapath side (drives St, returns accumulator LSB)
  modport master (output St, M, input Load, Ad, Sh, Busy, Done, Count);
  // slave: the controller itself
  modport slave  (input St, M, output Load, Ad, Sh, Busy, Done, Count);

endinterface

// File: rtl/mult_bit_counter.sv
// Counts multiplier bits shifted out; cleared by Load, advanced by Sh.
module mult_bit_counter #(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = 5
) (
  input  logic          Clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  always_ff @(posedge Clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign last = (count == CW'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Shift-add multiplier controller: sequences Load/Ad/Sh on the accumulator and runs the St/Done handshake.
module mult_ctrl
  import mult_pkg::*;
(
  input  logic        Clk,
  input  logic        rst,
  mult_ctrl_if.slave  bus
);

  state_t state;
  logic   load;
  logic   ad;
  logic   sh;
  logic   busy;
  logic   done;
  logic   last;

  // Strobes are decoded from state so the accumulator acts on the same edge the FSM advances.
  always_comb begin
    load = 1'b0;
    ad   = 1'b0;
    sh   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      TEST: begin
        busy = 1'b1;
        if (bus.M) ad = 1'b1;
        else       sh = 1'b1;
      end
      ADDSH: begin
        busy = 1'b1;
        sh   = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.St) state <= LOAD;
        LOAD:    state <= TEST;
        TEST: begin
          if (bus.M)     state <= ADDSH;
          else if (last) state <= DONE;
        end
        ADDSH:   state <= last ? DONE : TEST;
        DONE:    if (!bus.St) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mult_bit_counter #(
    .N  (N),
    .CW (CW)
  ) u_bit_counter (
    .Clk   (Clk),
    .rst   (rst),
    .clr   (load),
    .inc   (sh),
    .count (bus.Count),
    .last  (last)
  );

  assign bus.Load = load;
  assign bus.Ad   = ad;
  assign bus.Sh   = sh;
  assign bus.Busy = busy;
  assign bus.Done = done;

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a behavioural 33-bit accumulator and 17-bit adder around it.
module tb_mult_ctrl;

  logic        Clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] acc = '0;
  logic [15:0] mplier = '0;
  logic [15:0] mcand  = '0;
  int          ad_cnt = 0;
  int          sh_cnt = 0;
  int          excl_viol = 0;
  int          bd_viol = 0;
  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic [15:0] ra;
  logic [15:0] rb;

  mult_ctrl_if bus ();

  mult_ctrl dut (
    .Clk (Clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  assign bus.M = acc[0];

  always @(posedge Clk) begin
    if (bus.Load) begin
      acc    <= {17'd0, mplier};
      ad_cnt <= 0;
      sh_cnt <= 0;
    end else if (bus.Ad) begin
      acc[32:16] <= {1'b0, acc[31:16]} + {1'b0, mcand};
      ad_cnt     <= ad_cnt + 1;
    end else if (bus.Sh) begin
      acc    <= acc >> 1;
      sh_cnt <= sh_cnt + 1;
    end
  end

  always @(negedge Clk) begin
    if ((32'(bus.Load) + 32'(bus.Ad) + 32'(bus.Sh)) > 32'd1) excl_viol <= excl_viol + 1;
    if (bus.Busy && bus.Done) bd_viol <= bd_viol + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts an operation and counts edges from the St-sampling edge to the first Done cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int cycles);
    @(negedge Clk);
    mplier = a;
    mcand  = b;
    bus.St = 1'b1;
    @(posedge Clk);
    cycles = 0;
    while (cycles < 100) begin
      @(posedge Clk);
      cycles++;
      #1;
      if (bus.Done) break;
    end
    if (!bus.Done) chk("done_timeout", 64'(bus.Done), 64'd1);
  endtask

  task automatic finish_op();
    @(negedge Clk);
    bus.St = 1'b0;
    @(posedge Clk);
    #1;
    chk("idle_after_drop", 64'({bus.Done, bus.Busy, bus.Load}), 64'd0);
  endtask

  initial begin
    bus.St = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_outputs", 64'({bus.Load, bus.Ad, bus.Sh, bus.Busy, bus.Done}), 64'd0);
    chk("reset_count", 64'(bus.Count), 64'd0);
    @(negedge Clk);
    rst = 1'b0;

    // Abort mid-TEST after five shifts
    @(negedge Clk);
    mplier = 16'h0000;
    mcand  = 16'h0007;
    bus.St = 1'b1;
    @(negedge Clk);
    chk("load_cycle", 64'({bus.Load, bus.Busy}), 64'b11);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (sh_cnt == 5) break;
    end
    chk("count_before_abort", 64'(bus.Count), 64'd5);
    bus.St = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("abort_outputs", 64'({bus.Load, bus.Ad, bus.Sh, bus.Busy, bus.Done}), 64'd0);
    chk("abort_count", 64'(bus.Count), 64'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    rst = 1'b0;
    repeat (3) @(negedge Clk);
    chk("abort_stays_idle", 64'({bus.Busy, bus.Done, bus.Load}), 64'd0);

    // 5 x 3
    run_op(16'd5, 16'd3, lat);
    chk("lat_5x3", 64'(lat), 64'd19);
    chk("prod_5x3", 64'(acc[31:0]), 64'd15);
    chk("ad_5x3", 64'(ad_cnt), 64'd2);
    chk("sh_5x3", 64'(sh_cnt), 64'd16);
    chk("count_done", 64'(bus.Count), 64'd16);
    chk("busy_in_done", 64'(bus.Busy), 64'd0);
    finish_op();

    // Multiplier zero
    run_op(16'h0000, 16'hFFFF, lat);
    chk("lat_0", 64'(lat), 64'd17);
    chk("prod_0", 64'(acc[31:0]), 64'd0);
    chk("ad_0", 64'(ad_cnt), 64'd0);
    finish_op();

    // All ones, plus St held after Done
    run_op(16'hFFFF, 16'hFFFF, lat);
    chk("lat_ffff", 64'(lat), 64'd33);
    chk("prod_ffff", 64'(acc[31:0]), 64'hFFFE0001);
    chk("acc32_ffff", 64'(acc[32]), 64'd0);
    chk("ad_ffff", 64'(ad_cnt), 64'd16);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #1;
      chk("hold_done", 64'(bus.Done), 64'd1);
      chk("hold_no_load", 64'(bus.Load), 64'd0);
    end
    finish_op();
    @(negedge Clk);
    bus.St = 1'b1;
    @(posedge Clk);
    #1;
    chk("reraise_load", 64'(bus.Load), 64'd1);
    while (!bus.Done) @(posedge Clk);
    @(negedge Clk);
    bus.St = 1'b0;
    @(posedge Clk);

    // Random operations
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, lat);
      chk("rand_lat", 64'(lat), 64'(17 + $countones(ra)));
      chk("rand_prod", 64'(acc), 64'(ra) * 64'(rb));
      finish_op();
    end

    chk("mutual_exclusion", 64'(excl_viol), 64'd0);
    chk("busy_done_overlap", 64'(bd_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
